// File: rtl/cpu_defs.sv
// Shared CPU definitions: divider FSM encoding, default datapath width, DIV funct code.
package cpu_defs;

    localparam int unsigned DIV_WIDTH = 32;
    localparam logic [5:0]  DIV       = 6'h1a;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_e;

endpackage : cpu_defs

// File: rtl/div_step.sv
// One restoring-division iteration: shift in next dividend bit, compare, conditionally subtract.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_c_o,
    output logic [WIDTH-1:0] q_c_o
);

    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] r_diff;
    logic             ge;

    // Compare is done at WIDTH+1 bits; a taken subtract always leaves a result below the divisor,
    // so the low WIDTH bits of the difference are exact.
    always_comb begin
        r_shift = {r_i, q_i[WIDTH-1]};
        ge      = (r_shift >= {1'b0, d_i});
        r_diff  = r_shift[WIDTH-1:0] - d_i;
        r_c_o   = ge ? r_diff : r_shift[WIDTH-1:0];
        q_c_o   = {q_i[WIDTH-2:0], ge};
    end

endmodule : div_step

// File: rtl/div_unit.sv
// Multicycle signed divider: magnitude restoring divide over WIDTH steps, then sign fix-up.
module div_unit
    import cpu_defs::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             DivZero,
    output logic             DivStop,
    output logic             busy
);

    localparam int unsigned     CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             divzero_q, divzero_d;
    logic             divstop_q, divstop_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] a_mag_c, b_mag_c;
    logic [WIDTH-1:0] step_r_c, step_q_c;

    // Operand magnitudes; the most negative value maps to its unsigned magnitude.
    assign a_mag_c = A[WIDTH-1] ? -A : A;
    assign b_mag_c = B[WIDTH-1] ? -B : B;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i   (r_q),
        .q_i   (q_q),
        .d_i   (b_q),
        .r_c_o (step_r_c),
        .q_c_o (step_q_c)
    );

    // Next-state and datapath update for IDLE -> RUN -> FIX -> IDLE.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        q_d       = q_q;
        r_d       = r_q;
        b_d       = b_q;
        sign_q_d  = sign_q_q;
        sign_r_d  = sign_r_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divzero_d = 1'b0;
        divstop_d = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                if (DivCtrl) begin
                    if (B == '0) begin
                        divzero_d = 1'b1;
                        divstop_d = 1'b1;
                    end else begin
                        q_d      = a_mag_c;
                        b_d      = b_mag_c;
                        r_d      = '0;
                        count_d  = '0;
                        sign_q_d = A[WIDTH-1] ^ B[WIDTH-1];
                        sign_r_d = A[WIDTH-1];
                        state_d  = DIV_RUN;
                    end
                end
            end
            DIV_RUN: begin
                r_d     = step_r_c;
                q_d     = step_q_c;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_STEP) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                lo_d      = sign_q_q ? -q_q : q_q;
                hi_d      = sign_r_q ? -r_q : r_q;
                divstop_d = 1'b1;
                state_d   = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        busy_d = (state_d != DIV_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= DIV_IDLE;
            count_q   <= '0;
            q_q       <= '0;
            r_q       <= '0;
            b_q       <= '0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            divzero_q <= 1'b0;
            divstop_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            q_q       <= q_d;
            r_q       <= r_d;
            b_q       <= b_d;
            sign_q_q  <= sign_q_d;
            sign_r_q  <= sign_r_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divzero_q <= divzero_d;
            divstop_q <= divstop_d;
            busy_q    <= busy_d;
        end
    end

    assign HI      = hi_q;
    assign LO      = lo_q;
    assign DivZero = divzero_q;
    assign DivStop = divstop_q;
    assign busy    = busy_q;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table, corner sequences, random ops vs. arithmetic model.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        DivCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        DivZero;
    logic        DivStop;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .DivCtrl (DivCtrl),
        .A       (A),
        .B       (B),
        .HI      (HI),
        .LO      (LO),
        .DivZero (DivZero),
        .DivStop (DivStop),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    // Advance past the next rising edge; outputs are then stable for sampling and driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Plain signed-arithmetic reference: truncating quotient, remainder follows the dividend.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (sa == 32'sh8000_0000 && sb == -1) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endtask

    // Start one operation, optionally disturb inputs while busy, then check latency and results.
    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input bit scramble);
        int n;
        bit done;
        A = a;
        B = b;
        DivCtrl = 1'b1;
        tick();
        DivCtrl = 1'b0;
        n = 0;
        done = 1'b0;
        while (n < 60 && !done) begin
            if (scramble) begin
                A = $urandom;
                B = $urandom;
                DivCtrl = (n == 5);
            end
            tick();
            n++;
            if (n == 1) check({nm, "_busy"}, 32'(busy), 32'd1);
            if (DivStop) done = 1'b1;
        end
        DivCtrl = 1'b0;
        check({nm, "_done"}, 32'(done), 32'd1);
        check({nm, "_lat"}, 32'(n), 32'd33);
        check({nm, "_LO"}, LO, eq);
        check({nm, "_HI"}, HI, er);
        check({nm, "_dz"}, 32'(DivZero), 32'd0);
        tick();
        check({nm, "_stop1"}, 32'(DivStop), 32'd0);
        check({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] ra;
        logic [31:0] rb;
        int n;
        bit done;
        bit seen;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2]  = '{32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[3]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[4]  = '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0};
        vecs[5]  = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
        vecs[6]  = '{32'd0,          32'd5,          32'd0,          32'd0};
        vecs[7]  = '{32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0};
        vecs[8]  = '{32'd1,          32'h8000_0000,  32'd0,          32'd1};
        vecs[9]  = '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0};
        vecs[10] = '{32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          32'h7FFF_FFFF};
        vecs[11] = '{32'd9,          32'd3,          32'd3,          32'd0};

        reset = 1'b0;
        DivCtrl = 1'b0;
        A = '0;
        B = '0;
        tick();
        tick();
        check("rst_HI", HI, 32'd0);
        check("rst_LO", LO, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stop", 32'(DivStop), 32'd0);
        check("rst_dz", 32'(DivZero), 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b0);
        end

        // Divide by zero: single-cycle flag pair, results held, never busy.
        run_op("pre_dz", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        A = 32'd5;
        B = 32'd0;
        DivCtrl = 1'b1;
        tick();
        DivCtrl = 1'b0;
        check("dz_flag", 32'(DivZero), 32'd1);
        check("dz_stop", 32'(DivStop), 32'd1);
        check("dz_busy", 32'(busy), 32'd0);
        check("dz_LO", LO, 32'd14);
        check("dz_HI", HI, 32'd2);
        tick();
        check("dz_flag1", 32'(DivZero), 32'd0);
        check("dz_stop1", 32'(DivStop), 32'd0);
        check("dz_busy1", 32'(busy), 32'd0);

        // Reset mid-operation drops the result; a fresh op afterwards works.
        A = 32'd100;
        B = 32'd7;
        DivCtrl = 1'b1;
        tick();
        DivCtrl = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        check("mrst_HI", HI, 32'd0);
        check("mrst_LO", LO, 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_stop", 32'(DivStop), 32'd0);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (DivStop || busy) seen = 1'b1;
        end
        check("mrst_quiet", 32'(seen), 32'd0);
        run_op("restart", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // New request and operand changes during RUN are ignored.
        run_op("ignore", 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);

        // DivCtrl held high: second op launches on the first IDLE edge after DivStop.
        A = 32'd20;
        B = 32'd6;
        DivCtrl = 1'b1;
        tick();
        n = 0;
        done = 1'b0;
        while (n < 60 && !done) begin
            tick();
            n++;
            if (DivStop) done = 1'b1;
        end
        check("held1_done", 32'(done), 32'd1);
        check("held1_lat", 32'(n), 32'd33);
        check("held1_LO", LO, 32'd3);
        check("held1_HI", HI, 32'd2);
        A = 32'hFFFF_FFEC;
        n = 0;
        done = 1'b0;
        while (n < 60 && !done) begin
            tick();
            n++;
            DivCtrl = 1'b0;
            if (DivStop) done = 1'b1;
        end
        check("held2_done", 32'(done), 32'd1);
        check("held2_lat", 32'(n), 32'd34);
        check("held2_LO", LO, 32'hFFFF_FFFD);
        check("held2_HI", HI, 32'hFFFF_FFFE);
        tick();
        check("held2_stop1", 32'(DivStop), 32'd0);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(1, 20));
                1: rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if (rb == 32'd0) rb = 32'd3;
            if (i % 7 == 0) ra = ra >> $urandom_range(0, 31);
            ref_div(ra, rb, eq, er);
            run_op($sformatf("rnd%0d", i), ra, rb, eq, er, (i % 3 == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_div_unit
